// File: rtl/lisa_ssa_pkg.sv
// Shared definitions for the SSA writeback path.
// SSA_ID_W / NUM_SSA_REGS fix the SSA ID space (8-bit IDs, 256 registers).
// wb_req_t describes one writeback request at the default 32-bit data width.
// It is used by requester-side models and producers.
package lisa_ssa_pkg;
    localparam int SSA_ID_W     = 8;
    localparam int NUM_SSA_REGS = 256;
    localparam int WB_DATA_W    = 32;

    typedef logic [SSA_ID_W-1:0] ssa_id_t;

    typedef struct packed {
        logic                 valid;
        ssa_id_t              addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/lisa_ssa_wb_arbiter_if.sv
// Writeback bus between the requesters and the SSA writeback arbiter.
// Requester side : req_valid/req_addr/req_data in, req_ready back (flattened per requester).
// Regfile side   : rf_wen/rf_waddr/rf_wdata write port.
// Status         : ssa_violation plus the captured first-violation ID and source.
// modport master = requesters/observers, modport slave = the arbiter.
interface lisa_ssa_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 2
);
    import lisa_ssa_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*SSA_ID_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic                        rf_wen;
    ssa_id_t                     rf_waddr;
    logic [DATA_W-1:0]           rf_wdata;
    logic                        ssa_violation;
    ssa_id_t                     violation_addr;
    logic [SRC_W-1:0]            violation_src;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_wen, rf_waddr, rf_wdata,
        input  ssa_violation, violation_addr, violation_src
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_wen, rf_waddr, rf_wdata,
        output ssa_violation, violation_addr, violation_src
    );
endinterface

// File: rtl/lisa_ssa_wb_arbiter_rr.sv
// Round-robin arbiter, reusable for other shared regfile ports.
// Ports: clk, rst (sync, active-high), req (request vector),
//        advance (a grant was consumed this cycle), grant (one-hot or zero, combinational).
// The search starts at rr_ptr and wraps. On advance the pointer moves to the slot
// after the winner, so a continuously requesting slot waits at most NUM_REQ cycles.
module lisa_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    int               idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/lisa_ssa_wb_arbiter.sv
// SSA writeback arbiter: shares the single regfile write port among NUM_REQ requesters.
// Ports: clk, rst (sync, active-high), bus (lisa_ssa_wb_arbiter_if.slave):
//   req_valid/req_ready/req_addr/req_data handshake, registered rf_wen/rf_waddr/rf_wdata,
//   and the sticky ssa_violation with the first violating ID and requester index.
// A per-ID "assigned" bitmap enforces single assignment. A second write to an ID is
// accepted on the handshake, so the requester is released, but it is never written.
module lisa_ssa_wb_arbiter
    import lisa_ssa_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = NUM_SSA_REGS,
    parameter int SRC_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    lisa_ssa_wb_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ready;
    logic                xfer;
    logic [SRC_W-1:0]    sel_idx;
    ssa_id_t             sel_addr;
    logic [DATA_W-1:0]   sel_data;

    logic [NUM_REGS-1:0] assigned;
    logic                rf_wen;
    ssa_id_t             rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                ssa_violation;
    ssa_id_t             violation_addr;
    logic [SRC_W-1:0]    violation_src;

    lisa_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    // Ready is suppressed during reset so a request in that cycle is not consumed.
    assign ready = rst ? '0 : grant;
    assign xfer  = |(bus.req_valid & ready);

    // Mux the single granted request. ready is one-hot, so at most one slot matches.
    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_idx  = SRC_W'(i);
                sel_addr = bus.req_addr[SSA_ID_W*i +: SSA_ID_W];
                sel_data = bus.req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // The bitmap is read combinationally. A write accepted in cycle N is therefore
    // visible to a duplicate arriving in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            assigned       <= '0;
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            ssa_violation  <= 1'b0;
            violation_addr <= '0;
            violation_src  <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (xfer) begin
                if (!assigned[sel_addr]) begin
                    rf_wen             <= 1'b1;
                    rf_waddr           <= sel_addr;
                    rf_wdata           <= sel_data;
                    assigned[sel_addr] <= 1'b1;
                end else if (!ssa_violation) begin
                    ssa_violation  <= 1'b1;
                    violation_addr <= sel_addr;
                    violation_src  <= sel_idx;
                end
            end
        end
    end

    assign bus.req_ready      = ready;
    assign bus.rf_wen         = rf_wen;
    assign bus.rf_waddr       = rf_waddr;
    assign bus.rf_wdata       = rf_wdata;
    assign bus.ssa_violation  = ssa_violation;
    assign bus.violation_addr = violation_addr;
    assign bus.violation_src  = violation_src;
endmodule

// File: tb/tb_lisa_ssa_wb_arbiter.sv
// Self-checking bench for lisa_ssa_wb_arbiter.
// Directed scenarios compare against hand-derived constants. The random scenario
// compares against a behavioural model: round-robin search over the pending requests,
// a per-ID assigned table, and first-violation capture.
module tb_lisa_ssa_wb_arbiter;
    import lisa_ssa_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lisa_ssa_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) bus ();

    lisa_ssa_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .NUM_REGS(256), .SRC_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side state: each slot holds its request until it is granted.
    wb_req_t pend [N];

    // Reference model state.
    int            m_ptr;
    bit            m_assigned [256];
    logic          m_wen;
    logic [7:0]    m_waddr;
    logic [31:0]   m_wdata;
    logic          m_viol;
    logic [7:0]    m_vaddr;
    logic [SW-1:0] m_vsrc;

    task automatic model_reset();
        m_ptr = 0;
        foreach (m_assigned[i]) m_assigned[i] = 1'b0;
        m_wen = 0; m_waddr = 0; m_wdata = 0;
        m_viol = 0; m_vaddr = 0; m_vsrc = 0;
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = '0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
        pend[i].valid = 1'b1;
        pend[i].addr  = a;
        pend[i].data  = d;
    endtask

    // One clock cycle. Inputs are driven just after the edge. Ready is sampled 1ns
    // later. The model then advances, and registered outputs are sampled 1ns after
    // the next edge. A granted requester drops its request.
    task automatic step(input bit with_rst, output logic [N-1:0] obs_ready,
                        output logic [N-1:0] exp_ready);
        int g;
        rst = with_rst;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = pend[i].valid;
            bus.req_addr[8*i +: 8]    = pend[i].addr;
            bus.req_data[DW*i +: DW]  = pend[i].data;
        end
        #1;
        obs_ready = bus.req_ready;
        g = -1;
        if (!with_rst) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(m_ptr + k) % N].valid) g = (m_ptr + k) % N;
        end
        exp_ready = (g < 0) ? '0 : (N'(1) << g);
        if (with_rst) begin
            model_reset();
        end else begin
            m_wen = 1'b0;
            if (g >= 0) begin
                if (!m_assigned[pend[g].addr]) begin
                    m_wen = 1'b1; m_waddr = pend[g].addr; m_wdata = pend[g].data;
                    m_assigned[pend[g].addr] = 1'b1;
                end else if (!m_viol) begin
                    m_viol = 1'b1; m_vaddr = pend[g].addr; m_vsrc = SW'(g);
                end
                m_ptr = (g + 1) % N;
                pend[g].valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [N-1:0] o, e;
        clear_pend();
        step(1'b1, o, e);
        step(1'b1, o, e);
    endtask

    task automatic test_reset();
        logic [N-1:0] o, e;
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h60 + i), 32'h1234_0000 + i);
        step(1'b1, o, e);
        n_tests++; if (o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", o); end
        n_tests++; if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 8'h00 || bus.rf_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rf: got wen=%b addr=%h data=%h want 0/00/0", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        n_tests++; if (bus.ssa_violation !== 1'b0 || bus.violation_addr !== 8'h00 || bus.violation_src !== 2'd0) begin
            n_fail++; $display("FAIL reset_viol: got %b/%h/%0d want 0/00/0", bus.ssa_violation, bus.violation_addr, bus.violation_src); end
        step(1'b1, o, e);
        n_tests++; if (o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready2: got %b want 0000", o); end
        clear_pend();
    endtask

    task automatic test_single();
        logic [N-1:0] o, e;
        set_req(0, 8'h05, 32'hDEAD_BEEF);
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", o); end
        n_tests++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h05 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_write: got wen=%b addr=%h data=%h want 1/05/deadbeef", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        step(1'b0, o, e);
        n_tests++; if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 8'h05 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_idle: got wen=%b addr=%h data=%h want 0/05/deadbeef", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] o, e;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 32'hA000_0000 + i);
        for (int k = 0; k < N; k++) begin
            step(1'b0, o, e);
            n_tests++; if (o !== (4'b0001 << k)) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", k, o, 4'b0001 << k); end
            n_tests++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'(8'h10 + k) || bus.rf_wdata !== 32'hA000_0000 + k) begin
                n_fail++; $display("FAIL b2b_write%0d: got wen=%b addr=%h data=%h want 1/%h/%h", k, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, 8'(8'h10 + k), 32'hA000_0000 + k); end
        end
    endtask

    task automatic test_violation();
        logic [N-1:0] o, e;
        set_req(1, 8'h20, 32'h1111_1111);
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0010 || bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL viol_first: got ready=%b wen=%b want 0010/1", o, bus.rf_wen); end
        step(1'b0, o, e);
        set_req(3, 8'h20, 32'h3333_3333);
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b1000) begin n_fail++; $display("FAIL viol_ready: got %b want 1000", o); end
        n_tests++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL viol_wen: got %b want 0", bus.rf_wen); end
        n_tests++; if (bus.ssa_violation !== 1'b1 || bus.violation_addr !== 8'h20 || bus.violation_src !== 2'd3) begin
            n_fail++; $display("FAIL viol_capture: got %b/%h/%0d want 1/20/3", bus.ssa_violation, bus.violation_addr, bus.violation_src); end
        set_req(2, 8'h21, 32'h2222_2222);
        step(1'b0, o, e);
        set_req(0, 8'h21, 32'h0);
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0001 || bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL viol_second: got ready=%b wen=%b want 0001/0", o, bus.rf_wen); end
        n_tests++; if (bus.ssa_violation !== 1'b1 || bus.violation_addr !== 8'h20 || bus.violation_src !== 2'd3) begin
            n_fail++; $display("FAIL viol_sticky: got %b/%h/%0d want 1/20/3", bus.ssa_violation, bus.violation_addr, bus.violation_src); end
    endtask

    task automatic test_same_id_race();
        logic [N-1:0] o, e;
        do_reset();
        set_req(0, 8'h30, 32'hC0C0_0000);
        set_req(2, 8'h30, 32'hC2C2_2222);
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0001) begin n_fail++; $display("FAIL race_ready0: got %b want 0001", o); end
        n_tests++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h30 || bus.rf_wdata !== 32'hC0C0_0000) begin
            n_fail++; $display("FAIL race_write: got wen=%b addr=%h data=%h want 1/30/c0c00000", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0100) begin n_fail++; $display("FAIL race_ready2: got %b want 0100", o); end
        n_tests++; if (bus.rf_wen !== 1'b0 || bus.ssa_violation !== 1'b1 || bus.violation_addr !== 8'h30 || bus.violation_src !== 2'd2) begin
            n_fail++; $display("FAIL race_viol: got wen=%b viol=%b/%h/%0d want 0/1/30/2", bus.rf_wen, bus.ssa_violation, bus.violation_addr, bus.violation_src); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] o, e;
        int cnt, last, max_gap, next_addr;
        do_reset();
        cnt = 0; last = -1; max_gap = 0; next_addr = 8'h50;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i].valid) begin set_req(i, 8'(next_addr), 32'(next_addr)); next_addr++; end
            step(1'b0, o, e);
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL fair_grant c%0d: got %b want %b", c, o, e); end
            if (o[2] === 1'b1) begin
                if (last >= 0 && c - last > max_gap) max_gap = c - last;
                last = c; cnt++;
            end
        end
        n_tests++; if (cnt < 2) begin n_fail++; $display("FAIL fair_count: got %0d want >=2", cnt); end
        n_tests++; if (max_gap > 4) begin n_fail++; $display("FAIL fair_gap: got %0d want <=4", max_gap); end
        clear_pend();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] o, e;
        do_reset();
        set_req(0, 8'h42, 32'h4242_0000);
        step(1'b0, o, e);
        set_req(1, 8'h42, 32'h0);
        step(1'b0, o, e);
        set_req(2, 8'h41, 32'h4141_4141);
        step(1'b0, o, e);
        n_tests++; if (bus.rf_wen !== 1'b1 || bus.ssa_violation !== 1'b1) begin
            n_fail++; $display("FAIL rmid_setup: got wen=%b viol=%b want 1/1", bus.rf_wen, bus.ssa_violation); end
        set_req(0, 8'h40, 32'h4040_4040);
        step(1'b1, o, e);
        n_tests++; if (o !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready: got %b want 0000", o); end
        n_tests++; if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 8'h00 || bus.ssa_violation !== 1'b0 || bus.violation_addr !== 8'h00) begin
            n_fail++; $display("FAIL rmid_clear: got wen=%b addr=%h viol=%b vaddr=%h want 0/00/0/00", bus.rf_wen, bus.rf_waddr, bus.ssa_violation, bus.violation_addr); end
        step(1'b0, o, e);
        n_tests++; if (o !== 4'b0001 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h40 || bus.ssa_violation !== 1'b0) begin
            n_fail++; $display("FAIL rmid_post40: got ready=%b wen=%b addr=%h viol=%b want 0001/1/40/0", o, bus.rf_wen, bus.rf_waddr, bus.ssa_violation); end
        set_req(3, 8'h41, 32'h0);
        step(1'b0, o, e);
        n_tests++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h41 || bus.ssa_violation !== 1'b0) begin
            n_fail++; $display("FAIL rmid_post41: got wen=%b addr=%h viol=%b want 1/41/0", bus.rf_wen, bus.rf_waddr, bus.ssa_violation); end
    endtask

    task automatic test_random();
        logic [N-1:0] o, e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i].valid && $urandom_range(0, 1) == 1)
                    set_req(i, 8'(8'h80 + $urandom_range(0, 31)), $urandom);
            step(1'b0, o, e);
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, o, e); end
            n_tests++; if (bus.rf_wen !== m_wen || bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
                n_fail++; $display("FAIL rand_rf c%0d: got %b/%h/%h want %b/%h/%h", c, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, m_wen, m_waddr, m_wdata); end
            n_tests++; if (bus.ssa_violation !== m_viol || bus.violation_addr !== m_vaddr || bus.violation_src !== m_vsrc) begin
                n_fail++; $display("FAIL rand_viol c%0d: got %b/%h/%0d want %b/%h/%0d", c, bus.ssa_violation, bus.violation_addr, bus.violation_src, m_viol, m_vaddr, m_vsrc); end
        end
        clear_pend();
    endtask

    initial begin
        clear_pend();
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_violation();
        test_same_id_race();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lisa_ssa_wb_arbiter.md
Name: lisa_ssa_wb_arbiter

Overview:
Shares the single write port of the SSA register file among NUM_REQ writeback requesters (ALU, load unit, etc.) using round-robin arbitration and a valid/ready handshake. The block drives the regfile write port from a registered stage. It also enforces the single-assignment rule: a 256-bit "assigned" bitmap tracks which SSA IDs have been written. Any second write to an ID is dropped and reported through a sticky violation flag.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
DATA_W, 32, write data width; matches the regfile DATA_W
NUM_REGS, 256, SSA ID space; SSA IDs are 8 bits wide
SRC_W, 2, width of the requester index; equals clog2(NUM_REQ)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant; combinational, one-hot or zero
req_addr  in  NUM_REQ*8  flattened SSA IDs; requester i uses bits [8i+7:8i]
req_data  in  NUM_REQ*DATA_W  flattened write data; requester i uses bits [DATA_W*i+DATA_W-1 : DATA_W*i]
rf_wen  out  1  regfile write enable (registered)
rf_waddr  out  8  regfile write address (registered)
rf_wdata  out  DATA_W  regfile write data (registered)
ssa_violation  out  1  sticky: set when a write targets an already-assigned ID
violation_addr  out  8  SSA ID of the first violation
violation_src  out  SRC_W  requester index of the first violation

Behaviour:
- Reset (rst=1 at a clock edge):
  - rr_ptr=0; assigned bitmap all 0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - ssa_violation=0, violation_addr=0, violation_src=0.
  - req_ready=0 while rst is high, so no request is accepted.
- Arbitration is round-robin:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first valid index g gets req_ready[g]=1; every other ready bit is 0.
  - If no request is valid, all ready bits are 0.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds valid, addr and data stable until its transfer; valid must not depend on ready.
- Pointer update:
  - On a transfer from g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr is unchanged.
  - A requester asserting valid continuously is granted within NUM_REQ cycles.
- Accept path, one cycle of latency. At the edge ending the transfer cycle:
  - If assigned[addr]=0: rf_wen<=1, rf_waddr<=addr, rf_wdata<=data, assigned[addr]<=1.
  - If assigned[addr]=1 (violation): rf_wen<=0 and the write is dropped. The handshake still completes, so the requester is released.
    - If ssa_violation was 0: set ssa_violation, and capture violation_addr=addr and violation_src=g.
    - Later violations leave the captured fields unchanged.
  - With no transfer, rf_wen<=0; rf_waddr and rf_wdata hold their values.
- Throughput: one accepted write per cycle, back-to-back.
- Same-ID races:
  - Two requesters presenting the same ID in one cycle: only one is granted. The other is granted later and flagged as a violation.
  - A transfer in cycle N followed by a transfer to the same ID in cycle N+1 is detected, because the bitmap updates at the end of cycle N and is read combinationally in cycle N+1.
- ssa_violation clears only on rst.
- Reset mid-operation:
  - A transfer coincident with rst is discarded (ready is 0).
  - Any write already in the output register is cleared, so rf_wen=0 in the next cycle.
  - The bitmap is cleared, matching the regfile's own clearing of its valid bits.
- Addresses are 8 bits and index the bitmap directly. With NUM_REGS=256 no ID is out of range.

Decomposition:
- Shared package lisa_ssa_pkg holds:
  - SSA_ID_W=8, NUM_SSA_REGS=256.
  - A typedef for the SSA ID.
  - A wb_req struct {valid, addr, data}, if the flow allows SV.
- One sub-module, lisa_rr_arbiter: parameterised NUM_REQ, with inputs req and advance and output grant (one-hot). It holds rr_ptr internally and is reusable for the regfile's read ports later.
- The bitmap, accept logic and output register stay in the top module.

Test Plan:
- Reset, then req0 valid with addr=0x05, data=0xDEADBEEF → ready[0]=1 in the same cycle. Next cycle: rf_wen=1, rf_waddr=0x05, rf_wdata=0xDEADBEEF. The cycle after: rf_wen=0.
- All 4 requesters valid continuously with distinct IDs 0x10..0x13 → grants in order 0,1,2,3, then each requester drops valid after its grant. rf_wen=1 for 4 consecutive cycles with waddr 0x10,0x11,0x12,0x13.
- Write 0x20 via req1; later write 0x20 via req3 → second transfer completes (ready[3]=1), rf_wen stays 0, ssa_violation=1, violation_addr=0x20, violation_src=3. A further duplicate 0x21 via req0 leaves addr/src unchanged.
- req0 and req2 present ID 0x30 in the same cycle with rr_ptr=0 → req0 is written. req2 is granted next cycle and flagged, with violation_src=2.
- req2 held valid for 8 cycles while req0, req1 and req3 are also continuously valid → req2 is granted at least twice, and the gap between its grants is at most 4 cycles.
- rst asserted in the cycle a transfer to 0x40 would occur → no transfer, rf_wen=0 after reset, ssa_violation=0. A post-reset write to 0x40 succeeds without a violation.
